// File: rtl/fp_add_pipe_if.sv
// Operand/result bus for the pipelined floating-point adder.
//   valid_i/ready_o : operand handshake (issue side -> adder)
//   sa/ea/ma, sb/eb/mb : operand a/b sign, exponent, stored mantissa
//   valid_o/ready_i : result handshake (adder -> writeback side)
//   sc/ec/mc, flags_o : result fields and {invalid, overflow, inexact}
// master = operand issuer / result consumer, slave = the adder.
interface fp_add_pipe_if #(
  parameter int unsigned E = 8,
  parameter int unsigned M = 7
);
  logic         valid_i;
  logic         ready_o;
  logic         sa_i;
  logic [E-1:0] ea_i;
  logic [M-1:0] ma_i;
  logic         sb_i;
  logic [E-1:0] eb_i;
  logic [M-1:0] mb_i;
  logic         valid_o;
  logic         ready_i;
  logic         sc_o;
  logic [E-1:0] ec_o;
  logic [M-1:0] mc_o;
  logic [2:0]   flags_o;

  modport master (
    output valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, ready_i,
    input  ready_o, valid_o, sc_o, ec_o, mc_o, flags_o
  );

  modport slave (
    input  valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i, ready_i,
    output ready_o, valid_o, sc_o, ec_o, mc_o, flags_o
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder c = a + b with generic exponent/mantissa
// widths (default bfloat16), round-to-nearest-even, flush-to-zero for
// subnormals and IEEE-style special values.
// Ports:
//   clk    : clock, all state on rising edge
//   nreset : asynchronous active-low reset
//   bus    : fp_add_pipe_if.slave -- operand handshake in, result handshake out
// Pipeline: S1 classify/swap/align, S2 add/subtract + leading-zero count,
// S3 normalise/round/pack into the output registers. Latency 3, one result
// per cycle; every stage advances together when the output is free.
module fp_add_pipe #(
  parameter int unsigned E = 8,
  parameter int unsigned M = 7
) (
  input  logic         clk,
  input  logic         nreset,
  fp_add_pipe_if.slave bus
);

  localparam int unsigned W_EXT = M + 4;            // hidden + mantissa + guard/round/sticky
  localparam int unsigned W_SUM = M + 5;            // W_EXT plus carry
  localparam int unsigned W_SH  = 2 * W_EXT;        // alignment window incl. shifted-out half
  localparam int unsigned W_LZ  = $clog2(W_SUM + 1);
  localparam int unsigned W_DX  = E + 1;            // exponent difference, no wrap
  localparam int unsigned W_XP  = E + 2;            // signed exponent during normalisation
  localparam int unsigned EMAX  = (1 << E) - 1;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             s1_valid, s1_nan, s1_inv, s1_inf, s1_inf_sgn;
  logic             s1_sub, s1_sx, s1_zsgn;
  logic [E-1:0]     s1_ex;
  logic [W_EXT-1:0] s1_x, s1_y;

  logic             s2_valid, s2_nan, s2_inv, s2_inf, s2_inf_sgn;
  logic             s2_sx, s2_zsgn;
  logic [E-1:0]     s2_ex;
  logic [W_SUM-1:0] s2_sum;
  logic [W_LZ-1:0]  s2_lz;

  logic             valid_q, sc_q;
  logic [E-1:0]     ec_q;
  logic [M-1:0]     mc_q;
  logic [2:0]       fl_q;

  // All stages move together whenever the output register is empty or drained.
  logic adv;
  assign adv         = ~valid_q | bus.ready_i;
  assign bus.ready_o = adv;

  assign bus.valid_o = valid_q;
  assign bus.sc_o    = sc_q;
  assign bus.ec_o    = ec_q;
  assign bus.mc_o    = mc_q;
  assign bus.flags_o = fl_q;

  // ---------------------------------------------------------------------------
  // S1: classify, order by magnitude, align the smaller operand
  // ---------------------------------------------------------------------------
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic             inf_clash, a_ge;
  logic             spec_nan_c, spec_inv_c, spec_inf_c, spec_sgn_c;
  logic [M-1:0]     ma_f, mb_f, mx_c, my_c;
  logic [E-1:0]     ex_c, ey_c;
  logic             sx_c, sub_c, zsgn_c, x_nz, y_nz;
  logic [W_DX-1:0]  ediff_c, shamt_c;
  logic [W_SH-1:0]  y_wide_c;
  logic [W_EXT-1:0] x_ext_c, y_al_c;

  always_comb begin
    a_zero    = (bus.ea_i == '0);
    b_zero    = (bus.eb_i == '0);
    a_nan     = (&bus.ea_i) & (|bus.ma_i);
    b_nan     = (&bus.eb_i) & (|bus.mb_i);
    a_inf     = (&bus.ea_i) & ~(|bus.ma_i);
    b_inf     = (&bus.eb_i) & ~(|bus.mb_i);
    a_snan    = a_nan & ~bus.ma_i[M-1];
    b_snan    = b_nan & ~bus.mb_i[M-1];
    inf_clash = a_inf & b_inf & (bus.sa_i ^ bus.sb_i);

    spec_nan_c = a_nan | b_nan | inf_clash;
    spec_inv_c = a_snan | b_snan | inf_clash;
    spec_inf_c = (a_inf | b_inf) & ~spec_nan_c;
    spec_sgn_c = a_inf ? bus.sa_i : bus.sb_i;

    // Subnormal inputs are read as signed zero.
    ma_f = a_zero ? '0 : bus.ma_i;
    mb_f = b_zero ? '0 : bus.mb_i;

    // x is the larger magnitude; ties keep a as x.
    a_ge = ({bus.ea_i, ma_f} >= {bus.eb_i, mb_f});
    sx_c = a_ge ? bus.sa_i : bus.sb_i;
    ex_c = a_ge ? bus.ea_i : bus.eb_i;
    mx_c = a_ge ? ma_f     : mb_f;
    ey_c = a_ge ? bus.eb_i : bus.ea_i;
    my_c = a_ge ? mb_f     : ma_f;
    x_nz = |ex_c;
    y_nz = |ey_c;

    sub_c  = bus.sa_i ^ bus.sb_i;
    zsgn_c = ~sub_c & bus.sa_i;   // exact cancellation gives +0, like-signed zeros keep sign

    // Past W_EXT the whole of y lands in the lower half and becomes sticky only.
    ediff_c  = W_DX'(ex_c) - W_DX'(ey_c);
    shamt_c  = (ediff_c > W_DX'(W_EXT)) ? W_DX'(W_EXT) : ediff_c;
    y_wide_c = {y_nz, my_c, 3'b000, W_EXT'(0)} >> shamt_c;
    y_al_c   = {y_wide_c[W_SH-1:W_EXT+1], y_wide_c[W_EXT] | (|y_wide_c[W_EXT-1:0])};
    x_ext_c  = {x_nz, mx_c, 3'b000};
  end

  // ---------------------------------------------------------------------------
  // S2: magnitude add/subtract and leading-zero count
  // ---------------------------------------------------------------------------
  logic [W_SUM-1:0] sum_c;
  logic [W_LZ-1:0]  lz_c;

  always_comb begin
    sum_c = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
    lz_c  = W_LZ'(W_SUM);
    for (int unsigned i = 0; i < W_SUM; i++) begin
      if (sum_c[i]) lz_c = W_LZ'(W_SUM - 1 - i);
    end
  end

  // ---------------------------------------------------------------------------
  // S3: normalise, round to nearest even, range check, special override
  // ---------------------------------------------------------------------------
  logic [W_SUM-1:0] norm_c;
  logic [M-1:0]     mant_c;
  logic [M:0]       mant_r;
  logic [W_XP-1:0]  exp_r;
  logic             grd, rnd, stk, rnd_up, is_zero, uflow, oflow;
  logic             sc_c;
  logic [E-1:0]     ec_c;
  logic [M-1:0]     mc_c;
  logic [2:0]       fl_c;

  always_comb begin
    // Leading one moves to the top bit; a zero sum stays all zero.
    norm_c  = s2_sum << s2_lz;
    is_zero = ~norm_c[W_SUM-1];
    mant_c  = norm_c[W_SUM-2 -: M];
    grd     = norm_c[3];
    rnd     = norm_c[2];
    stk     = |norm_c[1:0];
    rnd_up  = grd & (rnd | stk | mant_c[0]);
    mant_r  = {1'b0, mant_c} + (M+1)'(rnd_up);
    // Mantissa carry-out leaves mant_r[M-1:0] all zero, so only the exponent moves.
    exp_r   = W_XP'(s2_ex) + W_XP'(1) - W_XP'(s2_lz) + W_XP'(mant_r[M]);
    uflow   = exp_r[W_XP-1] | (exp_r == '0);
    oflow   = ~exp_r[W_XP-1] & (exp_r >= W_XP'(EMAX));

    sc_c = s2_sx;
    ec_c = exp_r[E-1:0];
    mc_c = mant_r[M-1:0];
    fl_c = {2'b00, grd | rnd | stk};

    if (s2_nan) begin
      sc_c      = 1'b0;
      ec_c      = '1;
      mc_c      = '0;
      mc_c[M-1] = 1'b1;
      fl_c      = {s2_inv, 2'b00};
    end else if (s2_inf) begin
      sc_c = s2_inf_sgn;
      ec_c = '1;
      mc_c = '0;
      fl_c = 3'b000;
    end else if (is_zero) begin
      sc_c = s2_zsgn;
      ec_c = '0;
      mc_c = '0;
      fl_c = 3'b000;
    end else if (uflow) begin
      ec_c = '0;
      mc_c = '0;
      fl_c = 3'b001;
    end else if (oflow) begin
      ec_c = '1;
      mc_c = '0;
      fl_c = 3'b011;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers; a stalled output freezes the whole pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid   <= 1'b0;
      s1_nan     <= 1'b0;
      s1_inv     <= 1'b0;
      s1_inf     <= 1'b0;
      s1_inf_sgn <= 1'b0;
      s1_sub     <= 1'b0;
      s1_sx      <= 1'b0;
      s1_zsgn    <= 1'b0;
      s1_ex      <= '0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_valid   <= 1'b0;
      s2_nan     <= 1'b0;
      s2_inv     <= 1'b0;
      s2_inf     <= 1'b0;
      s2_inf_sgn <= 1'b0;
      s2_sx      <= 1'b0;
      s2_zsgn    <= 1'b0;
      s2_ex      <= '0;
      s2_sum     <= '0;
      s2_lz      <= '0;
      valid_q    <= 1'b0;
      sc_q       <= 1'b0;
      ec_q       <= '0;
      mc_q       <= '0;
      fl_q       <= 3'b000;
    end else if (adv) begin
      s1_valid   <= bus.valid_i;
      s1_nan     <= spec_nan_c;
      s1_inv     <= spec_inv_c;
      s1_inf     <= spec_inf_c;
      s1_inf_sgn <= spec_sgn_c;
      s1_sub     <= sub_c;
      s1_sx      <= sx_c;
      s1_zsgn    <= zsgn_c;
      s1_ex      <= ex_c;
      s1_x       <= x_ext_c;
      s1_y       <= y_al_c;

      s2_valid   <= s1_valid;
      s2_nan     <= s1_nan;
      s2_inv     <= s1_inv;
      s2_inf     <= s1_inf;
      s2_inf_sgn <= s1_inf_sgn;
      s2_sx      <= s1_sx;
      s2_zsgn    <= s1_zsgn;
      s2_ex      <= s1_ex;
      s2_sum     <= sum_c;
      s2_lz      <= lz_c;

      valid_q    <= s2_valid;
      if (s2_valid) begin
        sc_q <= sc_c;
        ec_q <= ec_c;
        mc_q <= mc_c;
        fl_q <= fl_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe (bfloat16 configuration): directed
// vector table with latency checks, handshake/stall sequences, an
// asynchronous reset mid-burst, and randomized traffic scored against an
// exact big-integer reference model.
module tb_fp_add_pipe;

  localparam int TE   = 8;
  localparam int TM   = 7;
  localparam int TW   = TE + TM + 1;
  localparam int EMAX = (1 << TE) - 1;
  localparam int BW   = (1 << TE) + TM + 2;   // wide enough for any finite operand as an integer

  typedef struct {
    logic [TW-1:0] c;
    logic [2:0]    f;
  } res_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [TW-1:0] c;
    logic [2:0]    f;
  } vec_t;

  logic clk;
  logic nreset;

  fp_add_pipe_if #(.E(TE), .M(TM)) bus ();

  fp_add_pipe #(.E(TE), .M(TM)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: exact integer sum of the two operands, then RNE at M+1 bits.
  // ---------------------------------------------------------------------------
  function automatic res_t ref_add(input logic [TW-1:0] a, input logic [TW-1:0] b);
    res_t          r;
    logic          sa, sb, rs, up, inexact;
    int            ea, eb, p, sh, e;
    logic [TM-1:0] ma, mb;
    logic          a_nan, b_nan, a_inf, b_inf;
    logic [BW-1:0] ia, ib, mag, keep, rem, half;
    logic [TW-1:0] qnan;

    qnan = {1'b0, {TE{1'b1}}, 1'b1, {(TM-1){1'b0}}};
    sa = a[TW-1]; ea = int'(a[TW-2:TM]); ma = a[TM-1:0];
    sb = b[TW-1]; eb = int'(b[TW-2:TM]); mb = b[TM-1:0];
    a_nan = (ea == EMAX) && (ma != 0);
    b_nan = (eb == EMAX) && (mb != 0);
    a_inf = (ea == EMAX) && (ma == 0);
    b_inf = (eb == EMAX) && (mb == 0);

    if (a_nan || b_nan) begin
      r.c = qnan;
      r.f = {(a_nan && !ma[TM-1]) || (b_nan && !mb[TM-1]), 2'b00};
      return r;
    end
    if (a_inf && b_inf && (sa != sb)) begin
      r.c = qnan; r.f = 3'b100; return r;
    end
    if (a_inf) begin r.c = {sa, {TE{1'b1}}, {TM{1'b0}}}; r.f = 3'b000; return r; end
    if (b_inf) begin r.c = {sb, {TE{1'b1}}, {TM{1'b0}}}; r.f = 3'b000; return r; end

    // value = integer * 2^(1 - bias - M); e = 0 reads as zero
    ia = (ea == 0) ? '0 : (BW'({1'b1, ma}) << (ea - 1));
    ib = (eb == 0) ? '0 : (BW'({1'b1, mb}) << (eb - 1));
    if (sa == sb) begin mag = ia + ib; rs = sa; end
    else if (ia >= ib) begin mag = ia - ib; rs = sa; end
    else begin mag = ib - ia; rs = sb; end

    if (mag == 0) begin
      r.c = {(sa == sb) ? sa : 1'b0, {(TW-1){1'b0}}};
      r.f = 3'b000;
      return r;
    end

    p = 0;
    for (int i = 0; i < BW; i++) if (mag[i]) p = i;
    up = 1'b0; inexact = 1'b0;
    if (p >= TM) begin
      sh      = p - TM;
      keep    = mag >> sh;
      rem     = mag - (keep << sh);
      half    = (sh > 0) ? (BW'(1) << (sh - 1)) : '0;
      up      = (sh > 0) && ((rem > half) || ((rem == half) && keep[0]));
      inexact = (rem != 0);
    end else begin
      keep = mag << (TM - p);
    end
    keep = keep + BW'(up);
    e = p - TM + 1;
    if (keep[TM+1]) begin keep = keep >> 1; e++; end

    if (e <= 0) begin
      r.c = {rs, {(TW-1){1'b0}}}; r.f = 3'b001;
    end else if (e >= EMAX) begin
      r.c = {rs, {TE{1'b1}}, {TM{1'b0}}}; r.f = 3'b011;
    end else begin
      r.c = {rs, TE'(e), keep[TM-1:0]}; r.f = {2'b00, inexact};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driving helpers
  // ---------------------------------------------------------------------------
  task automatic drive_ops(input logic [TW-1:0] a, input logic [TW-1:0] b);
    bus.sa_i = a[TW-1]; bus.ea_i = a[TW-2:TM]; bus.ma_i = a[TM-1:0];
    bus.sb_i = b[TW-1]; bus.eb_i = b[TW-2:TM]; bus.mb_i = b[TM-1:0];
  endtask

  function automatic logic [TW-1:0] rand_op();
    case ($urandom_range(0, 15))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7F80;
      3:       return 16'hFF80;
      4:       return 16'h7FC0;
      5:       return 16'h7F81;
      6:       return 16'h0001;
      7:       return 16'h7F7F;
      8:       return 16'h0080;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [TW-1:0] rand_near(input logic [TW-1:0] a);
    int e;
    e = int'(a[TW-2:TM]) + int'($urandom_range(0, 4)) - 2;
    if (e < 1) e = 1;
    if (e > EMAX - 1) e = EMAX - 1;
    return {1'($urandom), TE'(e), TM'($urandom)};
  endfunction

  // One isolated operation on an empty pipe: returns result and cycles to valid_o.
  task automatic run_one(input logic [TW-1:0] a, input logic [TW-1:0] b,
                         output logic [TW-1:0] c, output logic [2:0] f, output int lat);
    bus.ready_i = 1'b1;
    drive_ops(a, b);
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    c = {bus.sc_o, bus.ec_o, bus.mc_o};
    f = bus.flags_o;
    @(posedge clk); #1;
  endtask

  // Streaming engine: scoreboard of expected results, operand hold while
  // not accepted, output stability while stalled.
  res_t          exp_q[$];
  logic [TW-1:0] cur_a, cur_b;
  bit            holding   = 1'b0;
  bit            stall_prv = 1'b0;
  logic [18:0]   prv_out;
  int            n_in = 0, n_out = 0, n_stall = 0;

  task automatic step(input bit offer, input bit take);
    res_t exp_r;
    if (!holding) begin
      if (offer) begin
        cur_a = rand_op();
        case ($urandom_range(0, 3))
          0:       cur_b = rand_op();
          1:       cur_b = cur_a ^ 16'h8000;
          default: cur_b = rand_near(cur_a);
        endcase
        drive_ops(cur_a, cur_b);
        bus.valid_i = 1'b1;
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    bus.ready_i = take;
    @(negedge clk);
    if (stall_prv) begin
      check("stall_valid_held", 32'(bus.valid_o), 32'd1);
      check("stall_data_held", 32'({bus.sc_o, bus.ec_o, bus.mc_o, bus.flags_o}), 32'(prv_out));
    end
    stall_prv = bus.valid_o && !bus.ready_i;
    if (stall_prv) begin
      n_stall++;
      prv_out = {bus.sc_o, bus.ec_o, bus.mc_o, bus.flags_o};
      check("ready_o_stall", 32'(bus.ready_o), 32'd0);
    end
    if (bus.valid_o && bus.ready_i) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.valid_o), 32'd0);
      end else begin
        exp_r = exp_q.pop_front();
        check("stream_c", 32'({bus.sc_o, bus.ec_o, bus.mc_o}), 32'(exp_r.c));
        check("stream_flags", 32'(bus.flags_o), 32'(exp_r.f));
      end
    end
    if (bus.valid_i && bus.ready_o) begin
      exp_q.push_back(ref_add(cur_a, cur_b));
      n_in++;
    end
    holding = bus.valid_i && !bus.ready_o;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t vecs [16];

  initial begin
    logic [TW-1:0] c;
    logic [2:0]    f;
    int            lat, base_out, seen;

    vecs[0]  = '{16'h3F80, 16'h3F80, 16'h4000, 3'b000};
    vecs[1]  = '{16'h3F80, 16'h3B80, 16'h3F80, 3'b001};
    vecs[2]  = '{16'h3F80, 16'h3BC0, 16'h3F81, 3'b001};
    vecs[3]  = '{16'h7F7F, 16'h7F7F, 16'h7F80, 3'b011};
    vecs[4]  = '{16'h3F80, 16'hBF80, 16'h0000, 3'b000};
    vecs[5]  = '{16'h7F80, 16'hFF80, 16'h7FC0, 3'b100};
    vecs[6]  = '{16'h7FC0, 16'h3F80, 16'h7FC0, 3'b000};
    vecs[7]  = '{16'h7F80, 16'h3F80, 16'h7F80, 3'b000};
    vecs[8]  = '{16'h0080, 16'h8001, 16'h0080, 3'b000};
    vecs[9]  = '{16'h8000, 16'h8000, 16'h8000, 3'b000};
    vecs[10] = '{16'h0000, 16'h8000, 16'h0000, 3'b000};
    vecs[11] = '{16'h7F81, 16'h3F80, 16'h7FC0, 3'b100};
    vecs[12] = '{16'hFF80, 16'h4000, 16'hFF80, 3'b000};
    vecs[13] = '{16'hC000, 16'h3F80, 16'hBF80, 3'b000};
    vecs[14] = '{16'h0080, 16'h8081, 16'h8000, 3'b001};
    vecs[15] = '{16'h3F80, 16'h0080, 16'h3F80, 3'b001};

    nreset      = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    drive_ops('0, '0);
    #12;
    check("reset_valid_o", 32'(bus.valid_o), 32'd0);
    check("reset_ready_o", 32'(bus.ready_o), 32'd1);
    check("reset_result", 32'({bus.sc_o, bus.ec_o, bus.mc_o}), 32'd0);
    check("reset_flags", 32'(bus.flags_o), 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, each on an empty pipe
    for (int i = 0; i < 16; i++) begin
      run_one(vecs[i].a, vecs[i].b, c, f, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_c", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
    end

    // Eight back-to-back ops with the consumer stalled in cycles 4..6
    base_out = n_out;
    n_in = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      step(n_in < 8, !(cyc >= 4 && cyc <= 6));
    end
    check("burst_all_out", 32'(n_out - base_out), 32'd8);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);
    check("burst_stall_seen", 32'(n_stall > 0), 32'd1);

    // Async reset while results are pending and the output is stalled
    for (int cyc = 0; cyc < 5; cyc++) step(1'b1, cyc < 3);
    bus.valid_i = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("midreset_valid_o", 32'(bus.valid_o), 32'd0);
    check("midreset_ready_o", 32'(bus.ready_o), 32'd1);
    check("midreset_result", 32'({bus.sc_o, bus.ec_o, bus.mc_o, bus.flags_o}), 32'd0);
    exp_q.delete();
    holding   = 1'b0;
    stall_prv = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.ready_i = 1'b1;
      @(negedge clk);
      if (bus.valid_o) seen++;
      @(posedge clk); #1;
    end
    check("no_stale_after_reset", 32'(seen), 32'd0);
    run_one(16'h3F80, 16'h3F80, c, f, lat);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("post_reset_c", 32'(c), 32'h4000);

    // Randomized traffic with random backpressure
    n_in = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
    end
    for (int cyc = 0; cyc < 60 && (exp_q.size() > 0 || holding); cyc++) begin
      step(1'b0, 1'b1);
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_in_eq_out", 32'(n_out), 32'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
